// File: rtl/unshifter.sv
// ---------------------------------------------------------------------------
// unshifter: bit-deposit (PDEP) stage on a valid/ready stream.
//
// The low popcount(cfg_mask) bits of each input word are scattered, in
// order, onto the bit positions where cfg_mask is 1. All other output bits
// are zero. The mask is captured together with the data, so each beat keeps
// the mask that was present when it was accepted.
//
// Two-stage elastic pipeline:
//   S1 holds {data, mask} of the accepted beat (flag v1).
//   S2 is the output register, holding the already-deposited word (flag v2).
// The deposit logic sits between S1 and S2, so nothing but flops drives the
// output data and valid. Full throughput, fixed latency of two edges.
//
// sti_ready is combinational from sto_ready so that a full pipeline can
// accept a new beat on the same edge it hands one downstream.
// ---------------------------------------------------------------------------
module unshifter #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ctl_ena,
    input  logic          ctl_clr,
    input  logic [DW-1:0] cfg_mask,
    input  logic [DW-1:0] sti_data,
    input  logic          sti_valid,
    output logic          sti_ready,
    output logic [DW-1:0] sto_data,
    output logic          sto_valid,
    input  logic          sto_ready
);

    // Width of the running source-bit index used by the deposit function.
    localparam int KW = (DW > 2) ? $clog2(DW) : 1;

    // Scatter the low bits of data onto the set positions of mask, in order.
    function automatic logic [DW-1:0] deposit(
        input logic [DW-1:0] data,
        input logic [DW-1:0] mask
    );
        logic [DW-1:0] res;
        logic [KW-1:0] k;
        res = '0;
        k   = '0;
        for (int i = 0; i < DW; i++) begin
            if (mask[i]) begin
                res[i] = data[k];
                k      = k + 1'b1;
            end else begin
                res[i] = 1'b0;
            end
        end
        return res;
    endfunction

    // Pipeline state
    logic          v1_q,        v1_d;
    logic [DW-1:0] s1_data_q,   s1_data_d;
    logic [DW-1:0] s1_mask_q,   s1_mask_d;
    logic          v2_q,        v2_d;
    logic [DW-1:0] s2_data_q,   s2_data_d;

    // Handshake terms
    logic adv2_s;
    logic adv1_s;
    logic sti_ready_s;
    logic accept_s;

    // Stage advance conditions and upstream ready.
    always_comb begin
        adv2_s      = ~v2_q | sto_ready;
        adv1_s      = v1_q & adv2_s;
        sti_ready_s = rst & ctl_ena & ~ctl_clr & (~v1_q | adv2_s);
        accept_s    = sti_valid & sti_ready_s;
    end

    // Next-state for both stages; flush has top priority and leaves data as is.
    always_comb begin
        v1_d      = v1_q;
        s1_data_d = s1_data_q;
        s1_mask_d = s1_mask_q;
        v2_d      = v2_q;
        s2_data_d = s2_data_q;

        if (ctl_clr) begin
            v1_d = 1'b0;
            v2_d = 1'b0;
        end else begin
            // S1: load on accept, otherwise empty when its beat moves on.
            if (accept_s) begin
                v1_d      = 1'b1;
                s1_data_d = sti_data;
                s1_mask_d = cfg_mask;
            end else if (adv1_s) begin
                v1_d = 1'b0;
            end else begin
                v1_d = v1_q;
            end

            // S2: take the deposited word, otherwise empty once consumed.
            if (adv1_s) begin
                v2_d      = 1'b1;
                s2_data_d = deposit(s1_data_q, s1_mask_q);
            end else if (sto_ready) begin
                v2_d = 1'b0;
            end else begin
                v2_d = v2_q;
            end
        end
    end

    // Pipeline registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q      <= 1'b0;
            s1_data_q <= '0;
            s1_mask_q <= '0;
            v2_q      <= 1'b0;
            s2_data_q <= '0;
        end else begin
            v1_q      <= v1_d;
            s1_data_q <= s1_data_d;
            s1_mask_q <= s1_mask_d;
            v2_q      <= v2_d;
            s2_data_q <= s2_data_d;
        end
    end

    // Outputs: data and valid straight from S2, ready from the handshake.
    always_comb begin
        sti_ready = sti_ready_s;
        sto_data  = s2_data_q;
        sto_valid = v2_q;
    end

endmodule

// File: doc/unshifter.md
Name: unshifter

Overview:
- Inverse of the sample-compaction shifter: a bit-deposit (PDEP) stage on a valid/ready stream.
- Takes a packed word whose low popcount(cfg_mask) bits are meaningful. Scatters those bits, in order, onto the bit positions where cfg_mask is 1, and zero-fills all other positions.
- Sits on the readback/replay path, between the sample memory readout and the channel-domain consumers.
- Two-stage elastic pipeline: full throughput, fixed latency 2.

Parameters:
DW, 32, data width of both streams and of cfg_mask (≥2).

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
ctl_ena  in  1  1 = accept new input beats; 0 = stall input, in-flight beats still drain
ctl_clr  in  1  synchronous flush of the pipeline
cfg_mask  in  DW  channel mask; bit i = 1 means output bit i is populated
sti_data  in  DW  packed input word
sti_valid  in  1  input beat valid
sti_ready  out  1  input beat accepted when sti_valid & sti_ready at clk edge
sto_data  out  DW  expanded output word
sto_valid  out  1  output beat valid
sto_ready  in  1  downstream ready

Behaviour:
- Reset (rst=0, asynchronous, no clock needed):
  - v1=v2=0, S1 data/mask=0, sto_data=0, sto_valid=0.
  - sti_ready=0 while rst=0.
  - Operation resumes on the first edge after release.
- Stages:
  - S1 registers {sti_data, cfg_mask} with flag v1.
  - S2 is the output register (sto_data, sto_valid=v2).
  - cfg_mask is captured per beat in S1, so a mask change affects only beats accepted from that edge on. Beats already in S1/S2 keep the mask they were captured with.
- Advance rules:
  - adv2 = !v2 | sto_ready
  - adv1 = v1 & adv2
  - sti_ready = rst & ctl_ena & !ctl_clr & (!v1 | adv2). This is a combinational path from sto_ready; it is permitted.
- Per edge:
  - If accept: S1 loads the beat, v1=1. Else if adv1: v1=0.
  - If adv1: S2 loads deposit(S1), v2=1. Else if sto_ready: v2=0.
  - Simultaneous accept + adv1 is the normal full-rate case; no bubble.
- Deposit:
  - sto_data[i] = mask[i] ? data[k] : 0, where k = popcount(mask[i-1:0]) (k=0 for i=0).
  - Registered into S2; no logic between S2 and the outputs.
  - sti_data bits at or above popcount(mask) are ignored.
- Latency:
  - Beat accepted at edge N drives sto_valid=1 after edge N+1 and is consumed at edge N+2 if sto_ready=1.
  - Sustained throughput is 1 beat/clk.
- Backpressure:
  - sto_ready=0 holds sto_data/sto_valid stable.
  - S1 fills with at most one more beat, then sti_ready=0.
  - No loss, duplication or reordering.
- ctl_clr=1 at an edge: highest priority.
  - v1=v2=0; sto_data is left as is (don't-care).
  - No input is accepted that cycle (sti_ready=0).
  - sto_valid=0 from the following cycle.
- ctl_ena=0: sti_ready=0; S1/S2 continue to drain normally. ctl_clr overrides ctl_ena.
- Mask boundary values:
  - mask all-ones: identity.
  - mask all-zero: output 0 regardless of data.
  - mask with a single bit j: out[j]=data[0], all other bits 0.
- Reset mid-transfer discards all in-flight beats. The upstream handshake is considered aborted.

Test Plan:
- mask=0xFFFFFFFF, ena=1, sto_ready=1, push 0x00000011 -> sto_valid rises after the 2nd edge with sto_data=0x00000011; exactly one beat out.
- mask=0xFF00FF00, push 0x0000ABCD -> 0xAB00CD00. mask=0x0000000F, push 0xFFFFFFF5 -> 0x00000005. mask=0, push 0xFFFFFFFF -> 0x00000000. mask=0x80000000, push 0x1 -> 0x80000000.
- Back-to-back beats with per-beat mask change: (0x3, mask 0x0000000C) then (0x3, mask 0x00030000) -> 0x0000000C then 0x00030000, on consecutive cycles.
- sto_ready=0 for 6 cycles while offering 1,2,3:
  - only 1,2 accepted; sti_ready=0 afterwards.
  - sto_data holds 1 throughout the stall.
  - after release, outputs are 1,2,3 in order with no gaps.
- Two beats in flight, pulse ctl_clr for 1 cycle, then push 0x5 (mask all-ones):
  - sto_valid=0 the cycle after clr.
  - only 0x5 emerges; the flushed beats never appear.
  - ctl_ena=0 keeps sti_ready=0 but lets in-flight beats drain.
- Assert rst=0 between clock edges with sto_valid=1 -> sto_valid and sti_ready fall immediately. After release, streaming 0x11223344 (mask all-ones) works with latency 2.
